crt_113_128_to_bin: RTL and testbench

Sequential residue-to-binary (reverse) converter for the moduli pair {113, 128}. It accepts a residue pair (X mod 113, X mod 128) over a valid/ready handshake and reconstructs the unique X in 0..14463 using mixed-radix CRT. The multiplication by 128⁻¹ mod 113 is done iteratively with per-step modular reduction. The block sits downstream of the mod-113 forward reducers and closes the binary → RNS → binary path.

---
 rtl/crt_113_128_to_bin.sv | 104 ++++++++++
 tb/tb_crt_113_128_to_bin.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/crt_113_128_to_bin.sv
// Sequential residue-to-binary converter for moduli {113,128}: mixed-radix CRT,
// with t = (a - b) * 98 mod 113 computed by 7 Horner steps. Optional: CRT113_RANGE_CHECK_EN.
module crt_113_128_to_bin (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  r113,
   input  logic [6:0]  r128,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [13:0] x
`ifdef CRT113_RANGE_CHECK_EN
   ,
   output logic        err
`endif
);

   typedef enum logic [1:0] {IDLE, DIFF, MUL, OUT} state_t;

   localparam logic [6:0] M113 = 7'd113;
   localparam logic [7:0] M113W = 8'd113;
   localparam logic [7:0] INV128 = 8'd98;

   state_t     state;
   logic [6:0] a, r128_q, d, acc;
   logic [2:0] cnt;
`ifdef CRT113_RANGE_CHECK_EN
   logic       flag;
`endif

   logic [6:0] a_in, b, d_n, acc_n;
   logic [7:0] dbl, dbl_r, sum, sum_r;

   always_comb begin
      a_in  = (r113 >= M113) ? r113 - M113 : r113;
      b     = (r128_q >= M113) ? r128_q - M113 : r128_q;
      // 7-bit wraparound keeps a - b + 113 exact when a < b (result 1..112)
      d_n   = (a >= b) ? a - b : a - b + M113;
      dbl   = {acc, 1'b0};
      dbl_r = (dbl >= M113W) ? dbl - M113W : dbl;
      sum   = dbl_r + INV128;
      sum_r = (sum >= M113W) ? sum - M113W : sum;
      acc_n = d[cnt] ? sum_r[6:0] : dbl_r[6:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         x         <= '0;
         a         <= '0;
         r128_q    <= '0;
         d         <= '0;
         acc       <= '0;
         cnt       <= '0;
`ifdef CRT113_RANGE_CHECK_EN
         flag      <= 1'b0;
         err       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a        <= a_in;
               r128_q   <= r128;
               in_ready <= 1'b0;
               state    <= DIFF;
`ifdef CRT113_RANGE_CHECK_EN
               flag     <= (r113 >= M113);
               err      <= 1'b0;
`endif
            end
            DIFF: begin
               d     <= d_n;
               acc   <= '0;
               cnt   <= 3'd6;
               state <= MUL;
            end
            MUL: begin
               acc <= acc_n;
               cnt <= cnt - 3'd1;
               if (cnt == 3'd0) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
`ifdef CRT113_RANGE_CHECK_EN
                  x         <= flag ? 14'd0 : {acc_n, r128_q};
                  err       <= flag;
`else
                  x         <= {acc_n, r128_q};
`endif
               end
            end
            OUT: if (out_ready) begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crt_113_128_to_bin.sv
// Bench for crt_113_128_to_bin: directed pairs, hold, mid-operation reset and a
// randomized back-to-back sweep scored against X itself (residues derived from X).
module tb_crt_113_128_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [6:0]  r113, r128;
   logic [13:0] x;
`ifdef CRT113_RANGE_CHECK_EN
   logic        err;
`endif

   int tests = 0;
   int fails = 0;

   crt_113_128_to_bin dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .r113(r113), .r128(r128), .out_valid(out_valid), .out_ready(out_ready),
      .x(x)
`ifdef CRT113_RANGE_CHECK_EN
      , .err(err)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int k);
      int fixed [8] = '{0, 14463, 112, 113, 127, 128, 14335, 1000};
      if (k < 8) return fixed[k];
      return int'($urandom_range(0, 14463));
   endfunction

   // One complete transaction; optionally stalls OUT with a competing in_valid
   task automatic run_pair(input logic [6:0] p, input logic [6:0] q, input int exp_x,
                           input logic exp_err, input int hold, input string tag);
      int n;
      logic busy_ok, hold_ok;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk({tag, "_idle"}, in_ready, 1);
      r113 = p; r128 = q; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0; busy_ok = 1'b1;
      while (!out_valid && n < 30) begin
         busy_ok &= !in_ready;
         @(posedge clk); #1; n++;
      end
      // 8 edges after the accept edge is cycle 9 relative to the accept cycle
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_busy"}, busy_ok & !in_ready, 1);
      chk({tag, "_x"}, x, exp_x);
`ifdef CRT113_RANGE_CHECK_EN
      chk({tag, "_err"}, err, exp_err);
`else
      chk({tag, "_noerr"}, exp_err, 0);
`endif
      if (hold > 0) begin
         hold_ok = 1'b1;
         r113 = 7'd1; r128 = 7'd1; in_valid = 1'b1;
         repeat (hold) begin
            @(posedge clk); #1;
            hold_ok &= out_valid & !in_ready & (x == 14'(exp_x));
         end
         in_valid = 1'b0;
         chk({tag, "_hold"}, hold_ok, 1);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_fall"}, out_valid, 0);
      chk({tag, "_rdy_rise"}, in_ready, 1);
   endtask

   initial begin
      int exp_q[$];
      int cur, k, got, cyc, last, bad_space, n;
      logic rdy, ov;
      logic [13:0] xv;
      localparam int N = 400;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; r113 = '0; r128 = '0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_x", x, 0);
`ifdef CRT113_RANGE_CHECK_EN
      chk("rst_err", err, 0);
`endif
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // out_ready high before out_valid must not matter
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("early_ready", out_valid, 0);

      run_pair(7'd0,   7'd0,   0,     1'b0, 0,  "zero");
      run_pair(7'd96,  7'd104, 1000,  1'b0, 0,  "p1000");
      run_pair(7'd28,  7'd57,  12345, 1'b0, 0,  "p12345");
      run_pair(7'd112, 7'd127, 14463, 1'b0, 0,  "max");
      run_pair(7'd96,  7'd104, 1000,  1'b0, 20, "stall");

      // reset during the 4th MUL cycle
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      r113 = 7'd5; r128 = 7'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_x", x, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      run_pair(7'd28, 7'd57, 12345, 1'b0, 0, "post_abort");

`ifdef CRT113_RANGE_CHECK_EN
      run_pair(7'd120, 7'd5,   0,    1'b1, 0, "range_bad");
      run_pair(7'd96,  7'd104, 1000, 1'b0, 0, "range_ok");
`else
      // 120 is taken as 7: the X with X%113==7 and X%128==5 is 83*128+5
      run_pair(7'd120, 7'd5, 10629, 1'b0, 0, "prereduce");
`endif

      // back-to-back sweep, in_valid and out_ready held high throughout
      k = 0; got = 0; cyc = 0; last = -1; bad_space = 0;
      cur = pick(0);
      r113 = 7'(cur % 113); r128 = 7'(cur % 128);
      in_valid = 1'b1; out_ready = 1'b1;
      while (got < N && cyc < N * 12 + 50) begin
         rdy = in_ready; ov = out_valid; xv = x;
         @(posedge clk); #1;
         cyc++;
         if (rdy && in_valid) begin
            exp_q.push_back(cur);
            if (last >= 0 && cyc - last != 10) bad_space++;
            last = cyc;
            k++;
            if (k < N) begin
               cur = pick(k);
               r113 = 7'(cur % 113); r128 = 7'(cur % 128);
            end else in_valid = 1'b0;
         end
         if (ov) begin
            if (exp_q.size() > 0) chk("sweep_x", xv, exp_q.pop_front());
            else chk("sweep_extra", 1, 0);
            got++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("sweep_count", got, N);
      chk("sweep_accepts", k, N);
      chk("sweep_spacing", bad_space, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
